// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch / data) arbiter in front of a single memory
// controller. One transaction is in flight at a time; contention between the
// ports is resolved round-robin against the last grant.
//
// Ports
//   clk, reset             rising-edge clock, synchronous active-high reset
//   if_req/if_addr         fetch port request (read only) and address
//   if_rdata/if_done       fetch read data and one-cycle completion pulse
//   d_req/d_we/d_addr/
//   d_wdata                data port request, write enable, address, data
//   d_rdata/d_done         data read data and one-cycle completion pulse
//   m_valid/m_rw/m_addr/
//   m_wdata                memory request (level), 1=read/0=write, address, data
//   m_rdata/m_ready        memory read data and completion
//   err                    high with a done pulse that ended in timeout
//   owner                  current/last grant: 0=fetch, 1=data
module mem_arbiter #(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [AWIDTH-1:0] if_addr,
  output logic [DWIDTH-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [AWIDTH-1:0] d_addr,
  input  logic [DWIDTH-1:0] d_wdata,
  output logic [DWIDTH-1:0] d_rdata,
  output logic              d_done,
  output logic              m_valid,
  output logic              m_rw,
  output logic [AWIDTH-1:0] m_addr,
  output logic [DWIDTH-1:0] m_wdata,
  input  logic [DWIDTH-1:0] m_rdata,
  input  logic              m_ready,
  output logic              err,
  output logic              owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  // The counter holds (ISSUE cycles so far - 1), so the last permitted ISSUE
  // cycle is the one where it equals TIMEOUT-1.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic       grant;
  logic       grant_d;
  logic       timeout;

  assign timeout = (cnt == CNT_LAST);
  assign m_valid = (state == ISSUE);

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          grant = 1'b1;
          // Data wins if alone, or if both request and fetch held the last grant.
          grant_d   = d_req && (!if_req || (owner == 1'b0));
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (m_ready || timeout) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      owner    <= 1'b1;
      m_rw     <= 1'b1;
      m_addr   <= '0;
      m_wdata  <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
      if_done  <= 1'b0;
      d_done   <= 1'b0;
      err      <= 1'b0;
    end else begin
      state   <= state_nxt;
      if_done <= 1'b0;
      d_done  <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            owner   <= grant_d;
            m_addr  <= grant_d ? d_addr : if_addr;
            m_rw    <= grant_d ? ~d_we : 1'b1;
            m_wdata <= grant_d ? d_wdata : '0;
            cnt     <= '0;
          end
        end
        ISSUE: begin
          cnt <= cnt + 8'd1;
          // m_ready is checked first so it wins over a coincident timeout.
          if (m_ready) begin
            if (m_rw) begin
              if (owner) d_rdata  <= m_rdata;
              else       if_rdata <= m_rdata;
            end
            if (owner) d_done  <= 1'b1;
            else       if_done <= 1'b1;
          end else if (timeout) begin
            // A timed-out read returns zero; a timed-out write keeps d_rdata.
            if (m_rw) begin
              if (owner) d_rdata  <= '0;
              else       if_rdata <= '0;
            end
            if (owner) d_done  <= 1'b1;
            else       if_done <= 1'b1;
            err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          m_valid;
  logic          m_rw;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata = '0;
  logic          m_ready = 1'b0;
  logic          err;
  logic          owner;

  mem_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .m_valid(m_valid), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .err(err), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            port;   // 0 fetch, 1 data
    bit            rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit            err;
    logic [DW-1:0] eif;
    logic [DW-1:0] ed;
    int            vc;     // expected number of m_valid cycles
  } item_t;

  item_t         q[$];
  int            dq[$];
  logic [DW-1:0] rq[$];

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit            own = 1'b1;
  logic [DW-1:0] mif = '0;
  logic [DW-1:0] md  = '0;
  bit            mon_off = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares memory-side request and completion against the queue.
  int   vcnt = 0;
  logic pv   = 1'b0;
  always @(negedge clk) begin
    item_t it;
    if (mon_off) begin
      vcnt = 0;
      pv   = 1'b0;
      chk("no_done_in_abort", {62'd0, if_done, d_done}, 64'd0);
    end else begin
      if (m_valid) begin
        vcnt++;
        if (q.size() == 0) chk("spurious_valid", 64'd1, 64'd0);
        else begin
          chk("m_addr",  64'(m_addr),  64'(q[0].addr));
          chk("m_rw",    64'(m_rw),    64'(q[0].rw));
          chk("m_wdata", 64'(m_wdata), 64'(q[0].wdata));
        end
      end
      if (pv && !m_valid) chk("done_after_issue", 64'(if_done | d_done), 64'd1);
      if (if_done || d_done) begin
        if (q.size() == 0) chk("spurious_done", 64'd1, 64'd0);
        else begin
          it = q.pop_front();
          chk("done_port", {62'd0, if_done, d_done}, it.port ? 64'd1 : 64'd2);
          chk("err",       64'(err),      64'(it.err));
          chk("if_rdata",  64'(if_rdata), 64'(it.eif));
          chk("d_rdata",   64'(d_rdata),  64'(it.ed));
          chk("owner",     64'(owner),    64'(it.port));
          chk("valid_cycles", 64'(vcnt),  64'(it.vc));
        end
        vcnt = 0;
      end else begin
        chk("err_idle", 64'(err), 64'd0);
      end
      pv = m_valid;
    end
  end

  // Memory responder: answers after the scheduled number of wait cycles and
  // toggles m_ready randomly while no request is outstanding.
  int            rw_w = 0;
  int            rk   = 0;
  logic [DW-1:0] rdat = '0;
  logic          rv   = 1'b0;
  always @(negedge clk) begin
    if (m_valid) begin
      if (!rv) begin
        rw_w = (dq.size() != 0) ? dq.pop_front() : 0;
        rdat = (rq.size() != 0) ? rq.pop_front() : '0;
        rk   = 0;
      end
      m_ready = (rk == rw_w);
      m_rdata = (rk == rw_w) ? rdat : $urandom;
      rk++;
    end else begin
      m_ready = 1'($urandom_range(0, 1));
      m_rdata = $urandom;
    end
    rv = m_valid;
  end

  task automatic push_item(bit port, bit dwe, logic [AW-1:0] ifa, logic [AW-1:0] da,
                           logic [DW-1:0] dwd, int w, logic [DW-1:0] dat);
    item_t it;
    it.port  = port;
    it.rw    = port ? ~dwe : 1'b1;
    it.addr  = port ? da : ifa;
    it.wdata = port ? dwd : '0;
    it.err   = (w >= TO);
    it.vc    = (w >= TO) ? TO : w + 1;
    if (it.rw) begin
      if (port) md  = it.err ? '0 : dat;
      else      mif = it.err ? '0 : dat;
    end
    it.eif = mif;
    it.ed  = md;
    own    = port;
    q.push_back(it);
    dq.push_back(w);
    rq.push_back(dat);
  endtask

  task automatic do_round(bit fr, bit dr, bit dwe, logic [AW-1:0] ifa, logic [AW-1:0] da,
                          logic [DW-1:0] dwd, int wf, int wd,
                          logic [DW-1:0] fdat, logic [DW-1:0] ddat);
    bit first;
    first = (fr && dr) ? ~own : dr;
    if (fr && dr) begin
      if (first) begin
        push_item(1'b1, dwe, ifa, da, dwd, wd, ddat);
        push_item(1'b0, dwe, ifa, da, dwd, wf, fdat);
      end else begin
        push_item(1'b0, dwe, ifa, da, dwd, wf, fdat);
        push_item(1'b1, dwe, ifa, da, dwd, wd, ddat);
      end
    end else if (fr) push_item(1'b0, dwe, ifa, da, dwd, wf, fdat);
    else if (dr)     push_item(1'b1, dwe, ifa, da, dwd, wd, ddat);
    @(negedge clk);
    if_req  = fr;
    if_addr = ifa;
    d_req   = dr;
    d_we    = dwe;
    d_addr  = da;
    d_wdata = dwd;
    for (int c = 0; c < 200 && (if_req || d_req); c++) begin
      @(negedge clk);
      if (if_done) if_req = 1'b0;
      if (d_done)  d_req  = 1'b0;
    end
    if (if_req || d_req) begin
      bad++;
      $display("FAIL round_timeout: req still pending fetch=%0b data=%0b", if_req, d_req);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic chk_reset_vals();
    chk("rst_m_valid",  64'(m_valid),  64'd0);
    chk("rst_m_rw",     64'(m_rw),     64'd1);
    chk("rst_m_addr",   64'(m_addr),   64'd0);
    chk("rst_m_wdata",  64'(m_wdata),  64'd0);
    chk("rst_if_rdata", 64'(if_rdata), 64'd0);
    chk("rst_d_rdata",  64'(d_rdata),  64'd0);
    chk("rst_dones",    {62'd0, if_done, d_done}, 64'd0);
    chk("rst_err",      64'(err),      64'd0);
    chk("rst_owner",    64'(owner),    64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit fr, dr, dwe;
    int wf, wd;
    reset = 1'b1; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals();
    reset = 1'b0;

    // Fetch with three m_valid cycles
    do_round(1, 0, 0, 8'h10, 8'h00, 32'h0, 2, 0, 32'hDEADBEEF, 32'h0);
    // Data write leaves d_rdata untouched
    do_round(0, 1, 1, 8'h00, 8'h20, 32'h12345678, 0, 3, 32'h0, 32'h0);
    // Contention: fetch, data, fetch, data
    do_round(1, 1, 0, 8'h31, 8'h42, 32'hA5A5A5A5, 1, 2, 32'h11111111, 32'h22222222);
    do_round(1, 1, 1, 8'h33, 8'h44, 32'h5A5A5A5A, 0, 0, 32'h33333333, 32'h44444444);
    // Timeout, ready on the timeout edge, data read timeout, then normal
    do_round(1, 0, 0, 8'h50, 8'h00, 32'h0, 20, 0, 32'hCAFEF00D, 32'h0);
    do_round(1, 0, 0, 8'h51, 8'h00, 32'h0, 14, 0, 32'h0BADBEEF, 32'h0);
    do_round(0, 1, 0, 8'h00, 8'h52, 32'h77, 0, 15, 32'h0, 32'h87654321);
    do_round(0, 1, 0, 8'h00, 8'h53, 32'h78, 0, 1, 32'h0, 32'h13572468);
    // Zero-wait memory
    do_round(1, 0, 0, 8'h60, 8'h00, 32'h0, 0, 0, 32'hFEEDFACE, 32'h0);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 2))
        0:       begin fr = 1; dr = 0; end
        1:       begin fr = 0; dr = 1; end
        default: begin fr = 1; dr = 1; end
      endcase
      dwe = 1'($urandom_range(0, 1));
      wf  = ($urandom_range(0, 7) == 0) ? $urandom_range(15, 17) : $urandom_range(0, 5);
      wd  = (!dwe && $urandom_range(0, 7) == 0) ? $urandom_range(15, 17) : $urandom_range(0, 5);
      do_round(fr, dr, dwe, AW'($urandom), AW'($urandom), $urandom, wf, wd, $urandom, $urandom);
    end

    // Reset in the second ISSUE cycle aborts without a done pulse
    mon_off = 1'b1;
    dq.push_back(30);
    rq.push_back($urandom);
    @(negedge clk);
    if_req  = 1'b1;
    if_addr = 8'h77;
    for (int c = 0; c < 20 && !m_valid; c++) @(negedge clk);
    chk("abort_issue_seen", 64'(m_valid), 64'd1);
    @(negedge clk);
    reset  = 1'b1;
    if_req = 1'b0;
    @(negedge clk);
    chk_reset_vals();
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_abort_idle", 64'(m_valid), 64'd0);
    end
    own = 1'b1; mif = '0; md = '0;
    mon_off = 1'b0;
    // First contended grant after reset goes to fetch
    do_round(1, 1, 0, 8'h81, 8'h82, 32'h9, 1, 1, 32'hAAAA0001, 32'hBBBB0002);

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
